// File: rtl/serial_input_port.sv
// Purpose : 8N1 serial receiver that feeds characters to a machine's INPR/FGI input port.
// Latency : stop-bit sample to io_fgiset high is 2 cycles (io_fgi low, holding buffer empty).
// Backpr. : io_fgi high stalls delivery; one character is held, later ones are dropped (io_overrun).
//
// Ports
//   io_clock     : system clock, all state on the rising edge
//   io_reset_n   : asynchronous active-low reset
//   io_rxd       : asynchronous serial line, idle high, LSB first
//   io_fgi       : machine FGI flag (1 = previous character not yet taken)
//   io_inpr      : last delivered character, changes only with io_fgiset
//   io_fgiset    : one-cycle pulse that sets FGI and qualifies io_inpr
//   io_overrun   : sticky, a received character was dropped
//   io_frame_err : one-cycle pulse in the cycle a low stop bit is sampled
module serial_input_port #(
    parameter int CLKS_PER_BIT = 1335   // legal range 4..4095
) (
    input  logic       io_clock,
    input  logic       io_reset_n,
    input  logic       io_rxd,
    input  logic       io_fgi,
    output logic [7:0] io_inpr,
    output logic       io_fgiset,
    output logic       io_overrun,
    output logic       io_frame_err
);

    localparam int CW = 12;

    localparam logic [CW-1:0] BAUD_FULL = CW'(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // ------------------------------------------------------------------
    // Line synchronizer. Resets to 1 (idle) so reset release never looks
    // like a start bit.
    // ------------------------------------------------------------------
    logic [1:0] rx_sync;
    logic       rxs;

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], io_rxd};
        end
    end

    assign rxs = rx_sync[1];

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_nxt;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_nxt;
    logic          baud_exp;
    logic          char_vld;
    logic          frame_err;

    // A sample is taken in the cycle the counter reads 1; the half-bit
    // preload from IDLE puts every later sample in the middle of its bit.
    assign baud_exp = (baud_cnt == BAUD_ONE);

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        char_vld  = 1'b0;
        frame_err = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_nxt = ST_START;
                    bit_nxt   = 3'd0;
                    baud_nxt  = BAUD_HALF;
                end
            end

            ST_START: begin
                if (baud_exp) begin
                    baud_nxt = BAUD_FULL;
                    if (!rxs) begin
                        state_nxt = ST_DATA;
                    end else begin
                        // Line went back high by mid start bit: a glitch.
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt - BAUD_ONE;
                end
            end

            ST_DATA: begin
                if (baud_exp) begin
                    baud_nxt  = BAUD_FULL;
                    shift_nxt = {rxs, shift_reg[7:1]};
                    bit_nxt   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = ST_STOP;
                    end
                end else begin
                    baud_nxt = baud_cnt - BAUD_ONE;
                end
            end

            ST_STOP: begin
                if (baud_exp) begin
                    baud_nxt = BAUD_FULL;
                    if (rxs) begin
                        char_vld  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = ST_WAIT_HIGH;
                    end
                end else begin
                    baud_nxt = baud_cnt - BAUD_ONE;
                end
            end

            ST_WAIT_HIGH: begin
                // A broken frame leaves the line low; a new start bit is
                // only meaningful once the line has returned to idle.
                if (rxs) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= 8'hFF;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
        end
    end

    assign io_frame_err = frame_err;

    // ------------------------------------------------------------------
    // One-entry holding buffer and delivery to INPR/FGI
    // ------------------------------------------------------------------
    logic [7:0] pend_data;
    logic       pend_valid;
    logic       deliver;
    logic       accept;
    logic       drop;

    // The io_fgiset guard covers the cycle in which the machine's FGI has
    // not yet risen in response to our own pulse.
    assign deliver = pend_valid & ~io_fgi & ~io_fgiset;

    // A delivery in the same cycle frees the slot for the arriving char.
    assign accept  = char_vld & (~pend_valid | deliver);
    assign drop    = char_vld & pend_valid & ~deliver;

    always_ff @(posedge io_clock or negedge io_reset_n) begin
        if (!io_reset_n) begin
            pend_data  <= 8'h00;
            pend_valid <= 1'b0;
            io_inpr    <= 8'h00;
            io_fgiset  <= 1'b0;
            io_overrun <= 1'b0;
        end else begin
            if (accept) begin
                pend_data  <= shift_reg;
                pend_valid <= 1'b1;
            end else if (deliver) begin
                pend_valid <= 1'b0;
            end

            if (deliver) begin
                io_inpr <= pend_data;
            end
            io_fgiset <= deliver;

            if (drop) begin
                io_overrun <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_fgiset_single: assert property (@(posedge io_clock) disable iff (!io_reset_n)
        io_fgiset |=> !io_fgiset);

    a_overrun_sticky: assert property (@(posedge io_clock) disable iff (!io_reset_n)
        io_overrun |=> io_overrun);

    a_inpr_stable: assert property (@(posedge io_clock) disable iff (!io_reset_n)
        !deliver |=> $stable(io_inpr));

endmodule

// File: doc/serial_input_port.md
SERIAL_INPUT_PORT -- requirements
Module: serial_input_port

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 1335, io_clock cycles per serial bit (115200 baud at 6.5 ns clock); legal range 4..4095.
REQ-002 Port: io_clock  input  1  system clock; all state on rising edge.
REQ-003 Port: io_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: io_rxd  input  1  asynchronous serial line, 8N1 framing, idle high, LSB first.
REQ-005 Port: io_fgi  input  1  current state of the machine's FGI flag (1 = previous character not yet taken).
REQ-006 Port: io_inpr  output  8  character bus to the machine's INPR; holds the last delivered character.
REQ-007 Port: io_fgiset  output  1  one-cycle pulse; sets FGI and qualifies io_inpr.
REQ-008 Port: io_overrun  output  1  sticky; a received character was dropped.
REQ-009 Port: io_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 The design uses one clock (io_clock); io_reset_n is asynchronous and active-low.

Function
REQ-011 io_rxd passes through a 2-flop synchronizer reset to 1; all decisions use the synchronized value (rxs).
REQ-012 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: rxs==0 -> START, bit counter cleared, baud counter loaded with CLKS_PER_BIT/2 (integer divide).
REQ-014 START: on baud expiry, sample rxs; 0 -> DATA with baud counter reloaded to CLKS_PER_BIT; 1 -> IDLE (glitch rejected, no output activity).
REQ-015 DATA: on each expiry, shift rxs into bit 7 of the shift register (right shift); after 8th sample -> STOP.
REQ-016 STOP: on expiry, rxs==1 -> char valid, IDLE; rxs==0 -> io_frame_err pulses for the sampling cycle, char discarded, WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rxs==1, then IDLE; no start detection while in WAIT_HIGH.
REQ-018 Baud counter: decrements each cycle, "expiry" = value 1, reloads on expiry; samples fall mid-bit.
REQ-019 One-entry holding buffer (pend_data, pend_valid) sits between receiver and io_inpr.
REQ-020 Valid char arriving with pend_valid==0 -> loaded into the buffer next cycle, pend_valid=1.
REQ-021 Valid char arriving with pend_valid==1 -> new char dropped, io_overrun set to 1 and held until reset; buffer unchanged.
REQ-022 Delivery: in any cycle with pend_valid==1, io_fgi==0 and io_fgiset==0, next edge loads io_inpr<=pend_data, drives io_fgiset=1 for exactly one cycle, clears pend_valid.
REQ-023 The io_fgiset==0 guard blocks back-to-back delivery while FGI updates; minimum spacing between io_fgiset pulses is 2 cycles.
REQ-024 Simultaneous delivery and new valid char in the same cycle: delivery takes precedence and the buffer accepts the new char (no overrun).
REQ-025 Latency: stop-bit sample to io_fgiset high = 2 cycles when io_fgi==0 and buffer empty.
REQ-026 io_inpr changes only on the edge that raises io_fgiset; otherwise stable.
REQ-027 io_fgi held high indefinitely: buffer holds one character, further characters are dropped per REQ-021.

Reset
REQ-028 io_reset_n low: FSM->IDLE, counters 0, synchronizer and shift register all 1s (shift reg 8'hFF), pend_valid 0.
REQ-029 Reset output values: io_inpr 8'h00, io_fgiset 0, io_overrun 0, io_frame_err 0.
REQ-030 Reset mid-frame abandons the frame with no pulse; after release, the first falling edge on rxs starts a new frame.

Verification (CLKS_PER_BIT=8)
REQ-031 Send 8'h41 with io_fgi=0 -> io_inpr=8'h41 with a single 1-cycle io_fgiset 2 cycles after stop-bit sample; io_overrun=0.
REQ-032 io_rxd low pulse of 3 cycles -> no io_fgiset, no io_frame_err; FSM back to IDLE.
REQ-033 Send 8'h55 with stop bit 0 -> io_frame_err 1-cycle pulse, no io_fgiset; next 8'hAA after line high is delivered correctly.
REQ-034 io_fgi=1, send 8'h31 then 8'h32 -> no io_fgiset, io_overrun=1; drop io_fgi -> io_inpr=8'h31 with one io_fgiset.
REQ-035 io_fgi=1, send 8'h7E; release io_fgi one cycle before 8'h7F completes -> 8'h7E then 8'h7F delivered, pulses >=2 cycles apart, io_overrun=0.
REQ-036 Assert io_reset_n low during DATA of 8'h66 -> all outputs at reset values; next full frame 8'h0D delivered normally.
